uart_tx_arbiter: RTL

//  Shares one async UART transmitter among NUM_REQ byte requesters (e.g. per-hart console ports).

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters, with grant lock.
// Define UART_TX_ARB_LOCK_TIMEOUT_EN to force-release a lock whose owner goes quiet.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    localparam int unsigned GW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 lock_timeout,
    output logic [7:0]           tx_hold_reg,
    output logic                 rst_tx_empty,
    input  logic                 txrdy
);

    typedef enum logic [2:0] {StIdle, StAccept, StStart, StWaitLo, StWaitHi} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic            lock_q, lock_d;
    logic [7:0]      txh_q, txh_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic            cand_found;
    logic [GW-1:0]   cand_idx;

    // A held lock restricts the candidate set to the owner; otherwise rotate from rr_q.
    always_comb begin
        int unsigned j;
        cand_found = 1'b0;
        cand_idx   = '0;
        j          = 0;
        if (lock_q) begin
            cand_found = req_valid[owner_q];
            cand_idx   = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                j = (32'(rr_q) + k) % NUM_REQ;
                if (!cand_found && req_valid[j]) begin
                    cand_found = 1'b1;
                    cand_idx   = j[GW-1:0];
                end
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lto_q, lto_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        txh_d   = txh_q;
        gid_d   = gid_q;
        unique case (state_q)
            StIdle: begin
                if (txrdy && cand_found) begin
                    gnt_d   = cand_idx;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                if (req_valid[gnt_q]) begin
                    txh_d   = req_data[8*gnt_q +: 8];
                    gid_d   = gnt_q;
                    rr_d    = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);
                    lock_d  = req_lock[gnt_q];
                    owner_d = gnt_q;
                    state_d = StStart;
                end else begin
                    state_d = StIdle;
                end
            end
            StStart:  state_d = StWaitLo;
            StWaitLo: if (!txrdy) state_d = StWaitHi;
            StWaitHi: if (txrdy) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        cnt_d = cnt_q;
        lto_d = 1'b0;
        if ((state_q == StAccept && req_valid[gnt_q]) || !lock_q) begin
            cnt_d = '0;
        end else if (state_q == StIdle && !req_valid[owner_q]) begin
            if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                cnt_d  = '0;
                lock_d = 1'b0;
                lto_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            txh_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            txh_q   <= txh_d;
            gid_q   <= gid_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            lto_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lto_q <= lto_d;
        end
    end
    assign lock_timeout = lto_q;
`else
    assign lock_timeout = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (state_q == StAccept) req_ready[gnt_q] = 1'b1;
    end

    assign busy         = (state_q != StIdle);
    assign rst_tx_empty = (state_q == StStart);
    assign tx_hold_reg  = txh_q;
    assign grant_id     = gid_q;

endmodule
